// File: rtl/cr_tcipif_dbus_master.sv
// Single-outstanding LSU-to-TCIPIF data bus master: alignment check, bus
// handshake, completion/timeout tracking and a one-cycle LSU response.
module cr_tcipif_dbus_master #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        lsu_req_vld,
  output logic        lsu_req_rdy,
  input  logic [31:0] lsu_req_addr,
  input  logic [1:0]  lsu_req_size,
  input  logic        lsu_req_write,
  input  logic [31:0] lsu_req_wdata,
  input  logic        lsu_req_supv,
  input  logic        lsu_req_deny,
  input  logic        lsu_req_chk_fail,
  output logic        lsu_rsp_vld,
  output logic [31:0] lsu_rsp_data,
  output logic        lsu_rsp_err,
  output logic        lsu_rsp_timeout,
  output logic        bmu_tcipif_dbus_req,
  output logic        bmu_tcipif_dbus_write,
  output logic        bmu_tcipif_dbus_supv_mode,
  output logic        bmu_tcipif_dbus_acc_deny,
  output logic        bmu_tcipif_dbus_chk_fail,
  output logic [31:0] bmu_tcipif_dbus_addr,
  output logic [1:0]  bmu_tcipif_dbus_size,
  output logic [31:0] bmu_tcipif_dbus_wdata,
  input  logic        tcipif_bmu_dbus_grnt,
  input  logic        tcipif_bmu_dbus_trans_cmplt,
  input  logic        tcipif_bmu_dbus_data_vld,
  input  logic        tcipif_bmu_dbus_acc_err,
  input  logic [31:0] tcipif_bmu_dbus_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d, supv_q, supv_d, deny_q, deny_d, chk_q, chk_d;
  logic        err_q, err_d, tout_q, tout_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        misaligned;

  assign misaligned = (lsu_req_size == 2'd3) ||
                      ((lsu_req_size == 2'd1) && lsu_req_addr[0]) ||
                      ((lsu_req_size == 2'd2) && (lsu_req_addr[1:0] != 2'b00));

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      supv_q  <= 1'b0;
      deny_q  <= 1'b0;
      chk_q   <= 1'b0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      size_q  <= size_d;
      write_q <= write_d;
      supv_q  <= supv_d;
      deny_q  <= deny_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    size_d  = size_q;
    write_d = write_q;
    supv_d  = supv_q;
    deny_d  = deny_q;
    chk_d   = chk_q;
    err_d   = err_q;
    tout_d  = tout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_req_vld) begin
          addr_d  = lsu_req_addr;
          wdata_d = lsu_req_wdata;
          size_d  = lsu_req_size;
          write_d = lsu_req_write;
          supv_d  = lsu_req_supv;
          deny_d  = lsu_req_deny;
          chk_d   = lsu_req_chk_fail;
          data_d  = '0;
          tout_d  = 1'b0;
          cnt_d   = '0;
          err_d   = misaligned;
          state_d = misaligned ? S_RSP : S_REQ;
        end
      end
      S_REQ: begin
        // Bus status before grant belongs to someone else's transfer.
        if (tcipif_bmu_dbus_grnt) begin
          cnt_d = '0;
          if (tcipif_bmu_dbus_data_vld && !write_q) data_d = tcipif_bmu_dbus_data;
          if (tcipif_bmu_dbus_trans_cmplt) begin
            err_d   = tcipif_bmu_dbus_acc_err;
            state_d = S_RSP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (tcipif_bmu_dbus_data_vld && !write_q) data_d = tcipif_bmu_dbus_data;
        if (tcipif_bmu_dbus_trans_cmplt) begin
          err_d   = tcipif_bmu_dbus_acc_err;
          state_d = S_RSP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RSP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign lsu_req_rdy     = (state_q == S_IDLE);
  assign lsu_rsp_vld     = (state_q == S_RSP);
  assign lsu_rsp_err     = lsu_rsp_vld && err_q;
  assign lsu_rsp_timeout = lsu_rsp_vld && tout_q;
  assign lsu_rsp_data    = (lsu_rsp_vld && !err_q) ? data_q : 32'h0;

  // Bus attributes are only meaningful while the request is presented.
  assign bmu_tcipif_dbus_req       = (state_q == S_REQ);
  assign bmu_tcipif_dbus_write     = bmu_tcipif_dbus_req && write_q;
  assign bmu_tcipif_dbus_supv_mode = bmu_tcipif_dbus_req && supv_q;
  assign bmu_tcipif_dbus_acc_deny  = bmu_tcipif_dbus_req && deny_q;
  assign bmu_tcipif_dbus_chk_fail  = bmu_tcipif_dbus_req && chk_q;
  assign bmu_tcipif_dbus_addr      = bmu_tcipif_dbus_req ? addr_q : 32'h0;
  assign bmu_tcipif_dbus_size      = bmu_tcipif_dbus_req ? size_q : 2'h0;
  assign bmu_tcipif_dbus_wdata     = bmu_tcipif_dbus_req ? wdata_q : 32'h0;

endmodule

// File: tb/tb_cr_tcipif_dbus_master.sv
// Directed and randomized bench for cr_tcipif_dbus_master, checked against a
// transaction-level model of response timing, data and error outcome.
module tb_cr_tcipif_dbus_master;

  localparam int TO = 4;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b;
  logic        lsu_req_vld = 1'b0;
  logic        lsu_req_rdy;
  logic [31:0] lsu_req_addr = '0;
  logic [1:0]  lsu_req_size = '0;
  logic        lsu_req_write = 1'b0;
  logic [31:0] lsu_req_wdata = '0;
  logic        lsu_req_supv = 1'b0;
  logic        lsu_req_deny = 1'b0;
  logic        lsu_req_chk_fail = 1'b0;
  logic        lsu_rsp_vld;
  logic [31:0] lsu_rsp_data;
  logic        lsu_rsp_err;
  logic        lsu_rsp_timeout;
  logic        bmu_tcipif_dbus_req, bmu_tcipif_dbus_write, bmu_tcipif_dbus_supv_mode;
  logic        bmu_tcipif_dbus_acc_deny, bmu_tcipif_dbus_chk_fail;
  logic [31:0] bmu_tcipif_dbus_addr;
  logic [1:0]  bmu_tcipif_dbus_size;
  logic [31:0] bmu_tcipif_dbus_wdata;
  logic        tcipif_bmu_dbus_grnt = 1'b0;
  logic        tcipif_bmu_dbus_trans_cmplt = 1'b0;
  logic        tcipif_bmu_dbus_data_vld = 1'b0;
  logic        tcipif_bmu_dbus_acc_err = 1'b0;
  logic [31:0] tcipif_bmu_dbus_data = '0;

  int checks = 0;
  int errors = 0;

  cr_tcipif_dbus_master #(.TIMEOUT_CYC(TO)) dut (
    .forever_cpuclk              (forever_cpuclk),
    .cpurst_b                    (cpurst_b),
    .lsu_req_vld                 (lsu_req_vld),
    .lsu_req_rdy                 (lsu_req_rdy),
    .lsu_req_addr                (lsu_req_addr),
    .lsu_req_size                (lsu_req_size),
    .lsu_req_write               (lsu_req_write),
    .lsu_req_wdata               (lsu_req_wdata),
    .lsu_req_supv                (lsu_req_supv),
    .lsu_req_deny                (lsu_req_deny),
    .lsu_req_chk_fail            (lsu_req_chk_fail),
    .lsu_rsp_vld                 (lsu_rsp_vld),
    .lsu_rsp_data                (lsu_rsp_data),
    .lsu_rsp_err                 (lsu_rsp_err),
    .lsu_rsp_timeout             (lsu_rsp_timeout),
    .bmu_tcipif_dbus_req         (bmu_tcipif_dbus_req),
    .bmu_tcipif_dbus_write       (bmu_tcipif_dbus_write),
    .bmu_tcipif_dbus_supv_mode   (bmu_tcipif_dbus_supv_mode),
    .bmu_tcipif_dbus_acc_deny    (bmu_tcipif_dbus_acc_deny),
    .bmu_tcipif_dbus_chk_fail    (bmu_tcipif_dbus_chk_fail),
    .bmu_tcipif_dbus_addr        (bmu_tcipif_dbus_addr),
    .bmu_tcipif_dbus_size        (bmu_tcipif_dbus_size),
    .bmu_tcipif_dbus_wdata       (bmu_tcipif_dbus_wdata),
    .tcipif_bmu_dbus_grnt        (tcipif_bmu_dbus_grnt),
    .tcipif_bmu_dbus_trans_cmplt (tcipif_bmu_dbus_trans_cmplt),
    .tcipif_bmu_dbus_data_vld    (tcipif_bmu_dbus_data_vld),
    .tcipif_bmu_dbus_acc_err     (tcipif_bmu_dbus_acc_err),
    .tcipif_bmu_dbus_data        (tcipif_bmu_dbus_data)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  initial begin
    #500000;
    $error("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    tcipif_bmu_dbus_grnt        = 1'b0;
    tcipif_bmu_dbus_trans_cmplt = 1'b0;
    tcipif_bmu_dbus_data_vld    = 1'b0;
    tcipif_bmu_dbus_acc_err     = 1'b0;
  endtask

  // cmp_dly: cycles from grant to trans_cmplt (0 = with grant, <0 = never).
  task automatic txn(input logic [31:0] addr, input logic [1:0] size, input logic wr,
                     input logic [31:0] wdata, input logic supv, input logic deny,
                     input logic chkf, input int gnt_dly, input int cmp_dly,
                     input logic dvld, input logic accerr, input logic [31:0] rdata,
                     input logic noise);
    logic mis, timed_out, exp_err;
    logic [31:0] exp_data;
    int lat;
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    timed_out = (cmp_dly < 0) || (cmp_dly > TO);
    lat = timed_out ? TO : cmp_dly;
    exp_err = mis || timed_out || accerr;
    exp_data = (!exp_err && !wr && dvld) ? rdata : 32'h0;

    @(negedge forever_cpuclk);
    check("rdy_before_accept", lsu_req_rdy, 1);
    lsu_req_vld = 1'b1; lsu_req_addr = addr; lsu_req_size = size; lsu_req_write = wr;
    lsu_req_wdata = wdata; lsu_req_supv = supv; lsu_req_deny = deny; lsu_req_chk_fail = chkf;
    @(negedge forever_cpuclk);
    lsu_req_vld = 1'b0;
    if (mis) begin
      check("mis_no_req", bmu_tcipif_dbus_req, 0);
      check("mis_rsp_vld", lsu_rsp_vld, 1);
      check("mis_rsp", {lsu_rsp_err, lsu_rsp_timeout, lsu_rsp_data}, {1'b1, 1'b0, 32'h0});
      @(negedge forever_cpuclk);
      check("mis_rsp_once", {lsu_rsp_vld, bmu_tcipif_dbus_req, lsu_req_rdy}, 3'b001);
      return;
    end
    for (int k = 0; k <= gnt_dly; k++) begin
      check("req_held", bmu_tcipif_dbus_req, 1);
      check("rsp_before_grant", lsu_rsp_vld, 0);
      check("bus_addr_wdata", {bmu_tcipif_dbus_addr, bmu_tcipif_dbus_wdata}, {addr, wdata});
      check("bus_attrs", {bmu_tcipif_dbus_size, bmu_tcipif_dbus_write, bmu_tcipif_dbus_supv_mode,
                          bmu_tcipif_dbus_acc_deny, bmu_tcipif_dbus_chk_fail},
                         {size, wr, supv, deny, chkf});
      tcipif_bmu_dbus_data = $urandom;
      if (k < gnt_dly) begin
        bus_idle();
        tcipif_bmu_dbus_trans_cmplt = noise;
        tcipif_bmu_dbus_data_vld    = noise;
        tcipif_bmu_dbus_acc_err     = noise;
      end else begin
        bus_idle();
        tcipif_bmu_dbus_grnt = 1'b1;
        if (cmp_dly == 0) begin
          tcipif_bmu_dbus_trans_cmplt = 1'b1;
          tcipif_bmu_dbus_data_vld    = dvld;
          tcipif_bmu_dbus_acc_err     = accerr;
          tcipif_bmu_dbus_data        = rdata;
        end
      end
      @(negedge forever_cpuclk);
    end
    for (int e = 0; e <= lat + 2; e++) begin
      check("req_after_grant", bmu_tcipif_dbus_req, 0);
      check("rsp_vld_timing", lsu_rsp_vld, (e == lat));
      if (e == lat)
        check("rsp_payload", {lsu_rsp_err, lsu_rsp_timeout, lsu_rsp_data},
                             {exp_err, timed_out, exp_data});
      bus_idle();
      tcipif_bmu_dbus_data = $urandom;
      if ((!timed_out && e + 1 == cmp_dly) || (timed_out && e + 1 > lat)) begin
        tcipif_bmu_dbus_trans_cmplt = 1'b1;
        tcipif_bmu_dbus_data_vld    = timed_out ? 1'b1 : dvld;
        tcipif_bmu_dbus_acc_err     = timed_out ? 1'b0 : accerr;
        if (!timed_out) tcipif_bmu_dbus_data = rdata;
      end
      @(negedge forever_cpuclk);
    end
    bus_idle();
    check("rdy_after_rsp", lsu_req_rdy, 1);
  endtask

  initial begin
    cpurst_b = 1'b0;
    #1;
    check("rst_outputs", {lsu_rsp_vld, lsu_rsp_err, lsu_rsp_timeout, bmu_tcipif_dbus_req,
                          bmu_tcipif_dbus_write, bmu_tcipif_dbus_acc_deny}, 6'b0);
    check("rst_bus_addr", {bmu_tcipif_dbus_addr, lsu_rsp_data}, 64'h0);
    check("rst_rdy", lsu_req_rdy, 1);
    repeat (2) @(negedge forever_cpuclk);
    cpurst_b = 1'b1;

    // Word load with delayed grant and completion.
    txn(32'hE000E010, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 3, 1'b1, 1'b0, 32'h12345678, 1'b0);
    // Misaligned half store.
    txn(32'h20000003, 2'd1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    // Illegal size.
    txn(32'h20000000, 2'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    // Denied load answered with access error.
    txn(32'h00000100, 2'd2, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1, 1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    // Timeout then a normal byte load.
    txn(32'h40000004, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0, 32'h0, 1'b0);
    txn(32'h40000007, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 2, 1'b1, 1'b0, 32'h000000A5, 1'b0);
    // Completion on the timeout boundary beats the timeout.
    txn(32'h40000008, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, TO, 1'b1, 1'b0, 32'h55AA55AA, 1'b0);
    // Grant and completion together; stray status before grant.
    txn(32'h50000002, 2'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'h0000BEEF, 1'b0);
    txn(32'h50000010, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3, 1, 1'b1, 1'b0, 32'h13579BDF, 1'b1);
    // Store completion returns no data.
    txn(32'h60000000, 2'd2, 1'b1, 32'h87654321, 1'b0, 1'b0, 1'b0, 1, 2, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0);

    // Reset asserted while waiting for completion.
    @(negedge forever_cpuclk);
    lsu_req_vld = 1'b1; lsu_req_addr = 32'h70000000; lsu_req_size = 2'd2; lsu_req_write = 1'b0;
    lsu_req_deny = 1'b0; lsu_req_supv = 1'b0; lsu_req_chk_fail = 1'b0;
    @(negedge forever_cpuclk);
    lsu_req_vld = 1'b0;
    check("rst_mid_req", bmu_tcipif_dbus_req, 1);
    tcipif_bmu_dbus_grnt = 1'b1;
    @(negedge forever_cpuclk);
    bus_idle();
    @(negedge forever_cpuclk);
    cpurst_b = 1'b0;
    #1;
    check("rst_mid_outputs", {bmu_tcipif_dbus_req, lsu_rsp_vld, lsu_req_rdy}, 3'b001);
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    tcipif_bmu_dbus_trans_cmplt = 1'b1;
    tcipif_bmu_dbus_data_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge forever_cpuclk);
      bus_idle();
      check("rst_no_rsp", {lsu_rsp_vld, bmu_tcipif_dbus_req, lsu_req_rdy}, 3'b001);
    end

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [1:0]  s;
      a = $urandom;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      txn(a, s, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 7)) - 1, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_tcipif_dbus_master.md
CR_TCIPIF_DBUS_MASTER -- requirements
Module: cr_tcipif_dbus_master

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum number of cycles from grant to completion before the block forces an error; legal range 2..255.
REQ-002 forever_cpuclk  in  1  sole clock; all flops are rising-edge.
REQ-003 cpurst_b  in  1  reset, asynchronous, active-low.
REQ-004 lsu_req_vld  in  1  LSU access request valid.
REQ-005 lsu_req_rdy  out  1  block accepts a request this cycle.
REQ-006 lsu_req_addr  in  32  byte address.
REQ-007 lsu_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-008 lsu_req_write  in  1  1 = store, 0 = load.
REQ-009 lsu_req_wdata  in  32  store data.
REQ-010 lsu_req_supv  in  1  supervisor-mode access.
REQ-011 lsu_req_deny  in  1  protection check denied this access.
REQ-012 lsu_req_chk_fail  in  1  upstream check failure; forwarded on the bus.
REQ-013 lsu_rsp_vld  out  1  one-cycle response pulse.
REQ-014 lsu_rsp_data  out  32  load data; 0 for stores and for errors.
REQ-015 lsu_rsp_err  out  1  access error.
REQ-016 lsu_rsp_timeout  out  1  error was caused by timeout.
REQ-017 bmu_tcipif_dbus_req, _write, _supv_mode, _acc_deny, _chk_fail  out  1 each  bus request and attributes.
REQ-018 bmu_tcipif_dbus_addr (32), bmu_tcipif_dbus_size (2), bmu_tcipif_dbus_wdata (32)  out  bus address, size and write data.
REQ-019 tcipif_bmu_dbus_grnt, _trans_cmplt, _data_vld, _acc_err  in  1 each  bus responder status.
REQ-020 tcipif_bmu_dbus_data  in  32  bus read data.

Function
REQ-021 The block SHALL have states IDLE, REQ, WAIT and RSP, and SHALL have at most one access outstanding at any time.
REQ-022 lsu_req_rdy SHALL be 1 only in IDLE; a request is accepted when lsu_req_vld & lsu_req_rdy, and all request fields SHALL then be registered.
REQ-023 On accept, a misaligned access (size 1 with addr[0]=1, size 2 with addr[1:0]!=0, or size 3) SHALL go directly to RSP with err=1, timeout=0 and data=0, and SHALL NOT assert bmu_tcipif_dbus_req.
REQ-024 On accept, an aligned access SHALL go to REQ; in REQ, bmu_tcipif_dbus_req=1 and every bus attribute SHALL be driven from the registered fields, held stable until grant.
REQ-025 In REQ, tcipif_bmu_dbus_grnt=1 SHALL complete the handshake; the block SHALL go to WAIT and clear the timeout counter to 0, and req SHALL be 0 from the next cycle.
REQ-026 If grnt and trans_cmplt are both 1 in the same REQ cycle, the block SHALL treat it as completion and go directly to RSP.
REQ-027 In WAIT, the counter SHALL increment by 1 per cycle; on trans_cmplt the block SHALL go to RSP with err=acc_err and timeout=0.
REQ-028 Load data SHALL be captured on the cycle where data_vld=1 and write=0, in REQ-after-grant or WAIT; completion without data_vld, or any store, SHALL return data=0.
REQ-029 If err=1, data SHALL be forced to 0.
REQ-030 In WAIT, when the counter equals TIMEOUT_CYC-1 and trans_cmplt=0, the block SHALL go to RSP with err=1 and timeout=1.
REQ-031 If trans_cmplt and the timeout condition occur in the same cycle, trans_cmplt SHALL win.
REQ-032 In RSP, lsu_rsp_vld=1 for exactly one cycle with the registered data, err and timeout; the next state SHALL be IDLE.
REQ-033 Response latency: rsp_vld SHALL be asserted 1 cycle after completion, or 1 cycle after accept for a misaligned access.
REQ-034 trans_cmplt, data_vld or grnt arriving in IDLE, or in REQ before grant (for example a late completion after a timeout), SHALL be ignored.
REQ-035 The counter width SHALL be 8 bits and it SHALL saturate; it cannot wrap in any legal configuration.

Reset
REQ-036 On cpurst_b=0, asynchronously: state SHALL be IDLE, counter 0, and all registered fields 0.
REQ-037 During and after reset, bus req and attributes, lsu_rsp_vld/data/err/timeout SHALL all be 0, and lsu_req_rdy SHALL be 1 once in IDLE.
REQ-038 If reset is asserted mid-access, the block SHALL drop bmu_tcipif_dbus_req immediately and issue no response for the aborted access.

Verification
REQ-039 Word load at addr 0xE000E010, grant 2 cycles later, cmplt with data_vld and data 0x1234_5678 3 cycles after grant -> exactly one rsp_vld, data=0x12345678, err=0, timeout=0.
REQ-040 Half store at addr 0x...3 -> no bus req; rsp_vld on the next cycle with err=1, data=0.
REQ-041 Load with lsu_req_deny=1, responder returns acc_err with cmplt -> dbus_acc_deny=1 on the bus; rsp err=1, data=0.
REQ-042 Granted load, no cmplt, TIMEOUT_CYC=4 -> rsp err=1, timeout=1 four cycles after grant; a late cmplt is ignored and the next request completes correctly.
REQ-043 grnt and cmplt in the same cycle -> req deasserts next cycle; a single rsp_vld follows on the next cycle.
REQ-044 cpurst_b pulsed low while in WAIT -> req=0 and rsp_vld never asserted; rdy=1 after reset release.
